// File: rtl/branch_pc_update_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_update_unit
//
// Program-counter stage that sits after the branch-offset shifter. Each cycle
// it picks the next fetch address from one of four sources: sequential PC+4,
// branch target, J/JAL target or JR target. During a stall it holds PC and
// keeps one pending redirect (the newest request wins). Every redirect is
// followed by a one-cycle flush bubble for the IF/ID register.
//
// Ports
//   Clk                 in   1   clock, rising edge
//   Rst                 in   1   synchronous active-high reset
//   Stall               in   1   hold PC (hazard unit)
//   BranchTaken         in   1   branch resolved taken this cycle
//   BranchBasePC        in   32  PC+4 of the branch instruction
//   BranchOffsetShifted in   32  sign-extended immediate << 2
//   Jump                in   1   J/JAL request
//   JumpIndex           in   26  instr[25:0]
//   JumpReg             in   1   JR request
//   JumpRegAddr         in   32  rs value for JR
//   PC                  out  32  current fetch address
//   PCPlus4             out  32  PC + 4 (wraps modulo 2^32)
//   InstrValid          out  1   fetch at PC is valid (0 = bubble)
//   Flush               out  1   kill instruction in IF/ID this cycle
//   AlignErr            out  1   one-cycle pulse: JR target misaligned
// ---------------------------------------------------------------------------
module branch_pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchBasePC,
    input  logic [31:0] BranchOffsetShifted,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegAddr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic        Flush,
    output logic        AlignErr
);

    typedef enum logic [1:0] {StFetch, StHold, StRedirect} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_target_q;
    logic        pend_valid_q;
    logic        flush_q;
    logic        valid_q;
    logic        align_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        req;
    logic [31:0] req_target;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = BranchBasePC + BranchOffsetShifted;
    assign jump_target   = {pc_plus4[31:28], JumpIndex, 2'b00};
    assign jr_target     = {JumpRegAddr[31:2], 2'b00};

    assign req = JumpReg | BranchTaken | Jump;

    // Priority JR > branch > jump; lower-priority requests are simply dropped.
    always_comb begin
        req_target = jump_target;
        if (JumpReg) begin
            req_target = jr_target;
        end else if (BranchTaken) begin
            req_target = branch_target;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'd0;
            pend_valid_q  <= 1'b0;
            flush_q       <= 1'b0;
            valid_q       <= 1'b1;
            align_q       <= 1'b0;
        end else begin
            align_q <= JumpReg & (JumpRegAddr[1:0] != 2'b00);
            flush_q <= 1'b0;
            valid_q <= 1'b1;
            unique case (state_q)
                // REDIRECT lasts one cycle and otherwise behaves like FETCH,
                // which allows back-to-back redirects.
                StFetch, StRedirect: begin
                    if (req) begin
                        if (!Stall) begin
                            pc_q    <= req_target;
                            flush_q <= 1'b1;
                            valid_q <= 1'b0;
                            state_q <= StRedirect;
                        end else begin
                            pend_target_q <= req_target;
                            pend_valid_q  <= 1'b1;
                            state_q       <= StHold;
                        end
                    end else if (Stall) begin
                        state_q <= StHold;
                    end else begin
                        pc_q    <= pc_plus4;
                        state_q <= StFetch;
                    end
                end
                StHold: begin
                    if (Stall) begin
                        if (req) begin
                            pend_target_q <= req_target;
                            pend_valid_q  <= 1'b1;
                        end
                    end else if (req || pend_valid_q) begin
                        // A request arriving on the release cycle is the newest.
                        pc_q         <= req ? req_target : pend_target_q;
                        pend_valid_q <= 1'b0;
                        flush_q      <= 1'b1;
                        valid_q      <= 1'b0;
                        state_q      <= StRedirect;
                    end else begin
                        pc_q    <= pc_plus4;
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4;
    assign InstrValid = valid_q;
    assign Flush      = flush_q;
    assign AlignErr   = align_q;

endmodule
